// File: rtl/nanop_pkg.sv
// nanop_pkg -- definitions shared by the nanoprocessor controller, ALU and
// RAM test programs.
//   OP_*     : 4-bit opcodes carried in I[3:0]; I[7:4] must be zero for a
//              valid opcode.
//   state_t  : controller FSM states.
//   exec_t   : bundle of strobes that depend on the decoded instruction
//              during EXEC.
package nanop_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_XOR = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_SBC = 4'h7;
   localparam logic [3:0] OP_ROL = 4'h8;
   localparam logic [3:0] OP_ROR = 4'h9;
   localparam logic [3:0] OP_LDA = 4'hA;
   localparam logic [3:0] OP_STA = 4'hB;
   localparam logic [3:0] OP_OUT = 4'hC;
   localparam logic [3:0] OP_JMP = 4'hD;
   localparam logic [3:0] OP_JNC = 4'hE;
   localparam logic [3:0] OP_JNZ = 4'hF;

   typedef enum logic [1:0] {
      ST_F_INSTR = 2'd0,
      ST_F_ADDR  = 2'd1,
      ST_EXEC    = 2'd2
   } state_t;

   typedef struct packed {
      logic load_pc;
      logic load_acc;
      logic sel_acc;
      logic load_flags;
      logic load_out;
      logic write;
   } exec_t;

endpackage

// File: rtl/nanop_decode.sv
// nanop_decode -- purely combinational instruction decoder for the EXEC state.
//   i_instr : instruction register contents (opcode in [3:0], [7:4] must be 0)
//   i_c     : registered carry flag
//   i_z     : registered zero flag
//   o_strb  : EXEC-state strobes (jump, accumulator, flags, output, write)
module nanop_decode
   import nanop_pkg::*;
(
   input  logic [7:0] i_instr,
   input  logic       i_c,
   input  logic       i_z,
   output exec_t      o_strb
);

   always_comb begin
      o_strb = '0;
      // Any nonzero upper nibble makes the instruction a NOP.
      if (i_instr[7:4] == 4'h0) begin
         case (i_instr[3:0])
            OP_XOR, OP_AND, OP_OR, OP_ADD, OP_ADC,
            OP_SUB, OP_SBC, OP_ROL, OP_ROR: begin
               o_strb.load_acc   = 1'b1;
               o_strb.load_flags = 1'b1;
            end
            OP_LDA: begin
               o_strb.load_acc = 1'b1;
               o_strb.sel_acc  = 1'b1;
            end
            OP_STA: o_strb.write    = 1'b1;
            OP_OUT: o_strb.load_out = 1'b1;
            OP_JMP: o_strb.load_pc  = 1'b1;
            OP_JNC: o_strb.load_pc  = ~i_c;
            OP_JNZ: o_strb.load_pc  = ~i_z;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/nanop_ctrl.sv
// nanop_ctrl -- nanoprocessor control unit. Every instruction is two bytes
// (opcode, operand address) and runs in three cycles:
// F_INSTR -> F_ADDR -> EXEC.
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset; also blanks all outputs
//   I          : instruction register
//   C, Z       : registered carry / zero flags
//   Load_I     : load IR from DIN          Load_Addr : load address reg
//   Sel_Addr   : 0=PC, 1=address reg       Inc_PC    : PC + 1
//   Load_PC    : jump (PC <= address reg)  Load_Acc  : load accumulator
//   Sel_Acc    : 1=DIN, 0=ALU              Load_Flags: load C/Z
//   Load_Out   : output reg <= acc         WRITE     : mem[ADDR] <= acc
module nanop_ctrl
   import nanop_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] I,
   input  logic       C,
   input  logic       Z,
   output logic       Load_I,
   output logic       Load_Addr,
   output logic       Sel_Addr,
   output logic       Inc_PC,
   output logic       Load_PC,
   output logic       Load_Acc,
   output logic       Sel_Acc,
   output logic       Load_Flags,
   output logic       Load_Out,
   output logic       WRITE
);

   state_t r_state;
   exec_t  w_exec;

   nanop_decode u_decode (
      .i_instr (I),
      .i_c     (C),
      .i_z     (Z),
      .o_strb  (w_exec)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_F_INSTR;
      end else begin
         case (r_state)
            ST_F_INSTR: r_state <= ST_F_ADDR;
            ST_F_ADDR:  r_state <= ST_EXEC;
            default:    r_state <= ST_F_INSTR;
         endcase
      end
   end

   // Outputs are gated by reset_n so that a reset landing in EXEC cannot
   // produce a write or a PC change in that same cycle.
   always_comb begin
      Load_I     = 1'b0;
      Load_Addr  = 1'b0;
      Sel_Addr   = 1'b0;
      Inc_PC     = 1'b0;
      Load_PC    = 1'b0;
      Load_Acc   = 1'b0;
      Sel_Acc    = 1'b0;
      Load_Flags = 1'b0;
      Load_Out   = 1'b0;
      WRITE      = 1'b0;
      if (reset_n) begin
         case (r_state)
            ST_F_INSTR: begin
               Load_I = 1'b1;
               Inc_PC = 1'b1;
            end
            ST_F_ADDR: begin
               Load_Addr = 1'b1;
               Inc_PC    = 1'b1;
            end
            ST_EXEC: begin
               Sel_Addr   = 1'b1;
               Load_PC    = w_exec.load_pc;
               Load_Acc   = w_exec.load_acc;
               Sel_Acc    = w_exec.sel_acc;
               Load_Flags = w_exec.load_flags;
               Load_Out   = w_exec.load_out;
               WRITE      = w_exec.write;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nanop_ctrl.sv
module tb_nanop_ctrl;
   import nanop_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] I;
   logic       C, Z;
   logic       Load_I, Load_Addr, Sel_Addr, Inc_PC, Load_PC;
   logic       Load_Acc, Sel_Acc, Load_Flags, Load_Out, WRITE;

   nanop_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .I          (I),
      .C          (C),
      .Z          (Z),
      .Load_I     (Load_I),
      .Load_Addr  (Load_Addr),
      .Sel_Addr   (Sel_Addr),
      .Inc_PC     (Inc_PC),
      .Load_PC    (Load_PC),
      .Load_Acc   (Load_Acc),
      .Sel_Acc    (Sel_Acc),
      .Load_Flags (Load_Flags),
      .Load_Out   (Load_Out),
      .WRITE      (WRITE)
   );

   always #5 clk = ~clk;

   // Expected control words: {Load_I, Load_Addr, Sel_Addr, Inc_PC, Load_PC,
   //                          Load_Acc, Sel_Acc, Load_Flags, Load_Out, WRITE}
   localparam logic [9:0] V_IDLE = 10'b0000000000;
   localparam logic [9:0] V_FI   = 10'b1001000000;
   localparam logic [9:0] V_FA   = 10'b0101000000;
   localparam logic [9:0] V_EX   = 10'b0010000000;
   localparam logic [9:0] V_ALU  = 10'b0010010100;
   localparam logic [9:0] V_LDA  = 10'b0010011000;
   localparam logic [9:0] V_STA  = 10'b0010000001;
   localparam logic [9:0] V_OUT  = 10'b0010000010;
   localparam logic [9:0] V_JMP  = 10'b0010100000;

   // ---------------- datapath / memory model ----------------
   logic [7:0] mem [0:255];
   logic [7:0] img [0:255];
   logic       img_load = 1'b0;
   logic [7:0] pc, ar, ir, acc, out_reg;
   logic       c_flag, z_flag;
   int         write_cnt = 0;
   logic [7:0] addr, din;
   logic [9:0] alu_res;

   function automatic logic [9:0] alu(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic ci);
      logic [8:0] s;
      logic [7:0] r;
      logic       co;
      s = '0; r = a; co = 1'b0;
      case (op)
         OP_XOR: r = a ^ b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; co = s[8]; end
         OP_ADC: begin s = {1'b0, a} + {1'b0, b} + {8'b0, ci}; r = s[7:0]; co = s[8]; end
         OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; co = s[8]; end
         OP_SBC: begin s = {1'b0, a} - {1'b0, b} - {8'b0, ci}; r = s[7:0]; co = s[8]; end
         OP_ROL: begin r = {a[6:0], ci}; co = a[7]; end
         OP_ROR: begin r = {ci, a[7:1]}; co = a[0]; end
         default: r = a;
      endcase
      return {co, (r == 8'h00), r};
   endfunction

   assign addr    = Sel_Addr ? ar : pc;
   assign din     = mem[addr];
   assign alu_res = alu(ir[3:0], acc, din, c_flag);
   assign I = ir;
   assign C = c_flag;
   assign Z = z_flag;

   always @(posedge clk) begin
      if (img_load) begin
         for (int k = 0; k < 256; k++) mem[k] <= img[k];
      end else if (WRITE) begin
         mem[addr] <= acc;
      end
      if (WRITE) write_cnt <= write_cnt + 1;
      if (!reset_n) begin
         pc <= 8'h00; ar <= 8'h00; ir <= 8'h00; acc <= 8'h00;
         out_reg <= 8'h00; c_flag <= 1'b0; z_flag <= 1'b0;
      end else begin
         if (Load_I)    ir <= din;
         if (Load_Addr) ar <= din;
         if (Load_PC)     pc <= ar;
         else if (Inc_PC) pc <= pc + 8'd1;
         if (Load_Acc)  acc <= Sel_Acc ? din : alu_res[7:0];
         if (Load_Flags) begin
            c_flag <= alu_res[9];
            z_flag <= alu_res[8];
         end
         if (Load_Out)  out_reg <= acc;
      end
   end

   // ---------------- checking / scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      string      tag;
      logic [9:0] vec;
      int         pc;
   } exp_t;

   exp_t sb_q[$];

   wire [9:0] w_outs = {Load_I, Load_Addr, Sel_Addr, Inc_PC, Load_PC,
                        Load_Acc, Sel_Acc, Load_Flags, Load_Out, WRITE};

   always @(negedge clk) begin
      exp_t e;
      check_val("inc_and_jmp", {31'b0, Inc_PC & Load_PC}, 32'd0);
      check_val("wr_and_acc",  {31'b0, WRITE & Load_Acc}, 32'd0);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_val({e.tag, "/ctl"}, {22'b0, w_outs}, {22'b0, e.vec});
         if (e.pc >= 0) check_val({e.tag, "/pc"}, {24'b0, pc}, e.pc);
         $display("cycle %-14s ctl=%b pc=%02h", e.tag, w_outs, pc);
      end
   end

   // One clock cycle with its expected control word (and PC, -1 = skip).
   task automatic step(input string tag, input logic [9:0] vec, input int exp_pc);
      exp_t e;
      e.tag = tag; e.vec = vec; e.pc = exp_pc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One full instruction fetched from pc0.
   task automatic instr(input string tag, input logic [9:0] exec_vec, input int pc0);
      step({tag, "_fi"}, V_FI, pc0);
      step({tag, "_fa"}, V_FA, pc0 + 1);
      step({tag, "_ex"}, exec_vec, pc0 + 2);
   endtask

   task automatic do_reset(input logic load);
      img_load = load;
      reset_n  = 1'b0;
      step("rst0", V_IDLE, -1);
      step("rst1", V_IDLE, -1);
      img_load = 1'b0;
      reset_n  = 1'b1;
   endtask

   task automatic clear_img();
      for (int k = 0; k < 256; k++) img[k] = 8'h00;
   endtask

   initial begin
      // Program A: LDA 0x64 ; ADD 0x65 ; STA 0x6A
      clear_img();
      img[0] = {4'h0, OP_LDA}; img[1] = 8'h64;
      img[2] = {4'h0, OP_ADD}; img[3] = 8'h65;
      img[4] = {4'h0, OP_STA}; img[5] = 8'h6A;
      img[8'h64] = 8'd3; img[8'h65] = 8'd4;
      @(posedge clk);
      #1;
      do_reset(1'b1);
      instr("lda", V_LDA, 0);
      instr("add", V_ALU, 2);
      instr("sta", V_STA, 4);
      check_val("mem6A", {24'b0, mem[8'h6A]}, 32'd7);
      check_val("acc_a", {24'b0, acc}, 32'd7);
      check_val("wr_cnt_a", write_cnt, 32'd1);

      // Program B: NOP ; NOP ; JMP 0x00 at address 0x04
      clear_img();
      img[4] = {4'h0, OP_JMP}; img[5] = 8'h00;
      do_reset(1'b1);
      instr("nop0", V_EX, 0);
      instr("nop1", V_EX, 2);
      instr("jmp", V_JMP, 4);
      step("jmp_tgt", V_FI, 0);
      step("jmp_tgt_fa", V_FA, 1);
      step("jmp_tgt_ex", V_EX, 2);

      // Program C: flag-driven branches, OUT, upper-nibble NOP
      clear_img();
      img[8'h00] = {4'h0, OP_LDA}; img[8'h01] = 8'h80;
      img[8'h02] = {4'h0, OP_ADD}; img[8'h03] = 8'h81;
      img[8'h04] = {4'h0, OP_JNC}; img[8'h05] = 8'h20;
      img[8'h06] = {4'h0, OP_JNZ}; img[8'h07] = 8'h20;
      img[8'h08] = {4'h0, OP_LDA}; img[8'h09] = 8'h82;
      img[8'h0A] = {4'h0, OP_OR};  img[8'h0B] = 8'h83;
      img[8'h0C] = {4'h0, OP_JNZ}; img[8'h0D] = 8'h20;
      img[8'h20] = {4'h0, OP_OUT}; img[8'h21] = 8'h00;
      img[8'h22] = 8'h3C;          img[8'h23] = 8'h81;
      img[8'h24] = {4'h0, OP_JNC}; img[8'h25] = 8'h30;
      img[8'h80] = 8'hFF; img[8'h81] = 8'h01; img[8'h82] = 8'h05; img[8'h83] = 8'h00;
      do_reset(1'b1);
      instr("lda_ff", V_LDA, 8'h00);
      instr("add_01", V_ALU, 8'h02);
      check_val("acc_wrap", {24'b0, acc}, 32'h00);
      instr("jnc_nt", V_EX, 8'h04);
      instr("jnz_nt", V_EX, 8'h06);
      instr("lda_05", V_LDA, 8'h08);
      instr("or_00", V_ALU, 8'h0A);
      instr("jnz_t", V_JMP, 8'h0C);
      instr("out", V_OUT, 8'h20);
      check_val("out_reg", {24'b0, out_reg}, 32'h05);
      instr("op3c", V_EX, 8'h22);
      check_val("acc_3c", {24'b0, acc}, 32'h05);
      check_val("mem81_3c", {24'b0, mem[8'h81]}, 32'h01);
      instr("jnc_t", V_JMP, 8'h24);
      step("jnc_tgt", V_FI, 8'h30);

      // Program D: reset asserted during EXEC of STA
      clear_img();
      img[0] = {4'h0, OP_LDA}; img[1] = 8'h40;
      img[2] = {4'h0, OP_STA}; img[3] = 8'h41;
      img[8'h40] = 8'h55; img[8'h41] = 8'h00;
      do_reset(1'b1);
      instr("lda_55", V_LDA, 0);
      step("sta_fi", V_FI, 2);
      step("sta_fa", V_FA, 3);
      reset_n = 1'b0;
      step("sta_rst", V_IDLE, -1);
      reset_n = 1'b1;
      step("post_fi", V_FI, 0);
      step("post_fa", V_FA, 1);
      check_val("mem41", {24'b0, mem[8'h41]}, 32'h00);
      check_val("wr_cnt_d", write_cnt, 32'd1);
      check_val("sb_empty", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
